shift_add_mult: RTL and testbench
=================================

# shift_add_mult

Iterative radix-2 shift-and-add multiplier that consumes one operand pair per transaction and produces a 2·W-bit product after W compute cycles. It sits downstream of the combinational shift stage in the ALU datapath. It replaces a large combinational multiplier with one conditional add plus one 1-bit shift per clock. Signed and unsigned operands are both supported, with valid/ready handshakes on input and output.

## Interface
- W, default 8: operand width in bits (W ≥ 2); product is 2·W bits
- clk  input  1  rising-edge clock, the only clock
- nrst  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  W  multiplicand
- b  input  W  multiplier
- sgn  input  1  1: a, b, p are two's complement; 0: unsigned
- out_valid  output  1  product p is valid
- out_ready  input  1  consumer accepts p
- p  output  2·W  product

## Operation
- States: IDLE, RUN, DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
- Accept: on a rising edge with in_valid && in_ready:
  - capture ma = |a|, mb = |b| as W-bit unsigned (|x| = x when sgn = 0 or x ≥ 0)
  - capture neg = sgn & (a[W-1] ^ b[W-1])
  - clear acc (2·W bits) and cnt, go to RUN
- RUN step, one per edge:
  - if mb[0], acc += ma << cnt, where ma is zero-extended to 2·W bits
  - mb >>= 1, cnt += 1
  - on the step where cnt == W-1: load p = neg ? −acc_next : acc_next (2·W-bit two's complement), go to DONE
- DONE: p and out_valid held stable until out_ready. On an edge with out_ready high, go to IDLE.
- Width rules:
  - acc never overflows 2·W bits; the worst case, unsigned (2^W−1)², fits.
  - |−2^(W−1)| = 2^(W−1) is representable as W-bit unsigned, so signed (−128)·(−128) = 16384 is exact for W = 8.
- Operands a, b, sgn are sampled only at the accept edge; later changes are ignored.
- in_valid outside IDLE is ignored and never queued.
- Zero operand: still takes the full W steps; p = 0, and never −0 (negating 0 yields 0).
- Reset, asserted at any time including mid-RUN or in DONE:
  - the in-flight transaction is dropped
  - state = IDLE, acc = 0, cnt = 0, p = 0
  - out_valid = 0, in_ready = 1, both visible immediately and asynchronously

## Timing
- Reset values: in_ready = 1, out_valid = 0, p = 0.
- Accept at edge E0. RUN occupies edges E1..EW. out_valid rises after edge EW, giving a latency of W edges from accept to product.
- If out_ready is already high when DONE is entered, the transfer occurs at edge EW+1. in_ready is high after EW+1 and a new accept is possible at EW+2.
- Minimum issue interval is W+2 cycles (10 for W = 8). There is no overlap between transactions.
- Output backpressure holds DONE indefinitely, with p unchanged.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

## Test plan
- Unsigned, W = 8: a = 255, b = 255, sgn = 0, out_ready = 1 → out_valid rises exactly 8 edges after accept with p = 65025 (0xFE01); in_ready returns 1 edge later.
- Signed: (a = −128, b = −128) → p = 16384; (a = −3, b = 7) → p = 0xFFEB (−21); (a = 127, b = −1) → p = 0xFF81 (−127).
- Zero and identity: a = 0, b = 0xAB → p = 0; a = 0x5A, b = 1 → p = 0x005A; latency is still 8 in both cases.
- Backpressure:
  - hold out_ready = 0 for 20 cycles after out_valid: p is stable, in_ready stays 0, and in_valid pulses with new operands are ignored
  - then raise out_ready: transfer completes, and the next accepted pair produces its own correct product
- Reset mid-RUN: deassert nrst at step 4 of a 200·100 computation → out_valid = 0, p = 0, and in_ready = 1 immediately. After release, a fresh 12·12 yields p = 144.
- Randomised back-to-back: 1000 random (a, b, sgn) pairs with random in_valid/out_ready gaps, checked against a reference product. The issue interval is never below 10 cycles, and there is exactly one output per accepted input, in order.

Source files
------------

// File: rtl/shift_add_mult_if.sv
// Operand/product handshake bundle for shift_add_mult.
//   master: drives in_valid, a, b, sgn, out_ready; observes in_ready, out_valid, p
//   slave : the multiplier side of the same signals
interface shift_add_mult_if #(
    parameter int unsigned W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             sgn;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   p;

    modport master (
        output in_valid, a, b, sgn, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, sgn, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/shift_add_mult.sv
// Iterative radix-2 shift-and-add multiplier, signed or unsigned operands.
// One conditional add and one 1-bit multiplier shift per clock; product
// appears W edges after accept and is held until the consumer takes it.
//   clk  : rising-edge clock
//   nrst : asynchronous active-low reset
//   bus  : slave side of shift_add_mult_if (in_valid/in_ready/a/b/sgn,
//          out_valid/out_ready/p)
module shift_add_mult #(
    parameter int unsigned W = 8
) (
    input logic              clk,
    input logic              nrst,
    shift_add_mult_if.slave  bus
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    ma_q, ma_d;
    logic [W-1:0]    mb_q, mb_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   p_q, p_d;

    logic [PW-1:0]   addend_c;
    logic [PW-1:0]   acc_nx_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            ma_q    <= '0;
            mb_q    <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    // Partial product for this step: ma placed at bit position cnt
    always_comb begin
        addend_c = mb_q[0] ? (PW'(ma_q) << cnt_q) : '0;
        acc_nx_c = acc_q + addend_c;
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        p_d     = p_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    // Magnitudes fit W unsigned bits, including |-2^(W-1)|
                    ma_d    = (bus.sgn && bus.a[W-1]) ? W'(-bus.a) : bus.a;
                    mb_d    = (bus.sgn && bus.b[W-1]) ? W'(-bus.b) : bus.b;
                    neg_d   = bus.sgn & (bus.a[W-1] ^ bus.b[W-1]);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_nx_c;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    // Negating a zero accumulator yields zero, never -0
                    p_d     = neg_q ? PW'(-acc_nx_c) : acc_nx_c;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake flags decode straight from the state register
    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.p         = p_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult (W = 8): the driver pushes expected
// products and accept cycles on each accept; an independent monitor pops and
// compares on each output transfer and checks accept-to-valid latency.
module tb_shift_add_mult;

    localparam int unsigned W = 8;

    logic clk;
    logic nrst;

    shift_add_mult_if #(.W(W)) ifc ();

    shift_add_mult #(.W(W)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            last_acc = -1;
    int            n_acc = 0;
    int            n_out = 0;
    logic [15:0]   exp_q[$];
    int            acc_cyc_q[$];
    logic          ov_prev = 1'b0;
    logic          rand_phase = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic s);
        int x;
        int y;
        x = s ? int'($signed(a)) : int'(a);
        y = s ? int'($signed(b)) : int'(b);
        return 16'(x * y);
    endfunction

    // Offer one pair, wait for acceptance, record expectation, then scramble operands
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp);
        int n;
        n = 0;
        @(posedge clk); #1;
        ifc.in_valid = 1'b1;
        ifc.a        = a;
        ifc.b        = b;
        ifc.sgn      = s;
        forever begin
            @(negedge clk);
            if (ifc.in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 32'(n), 32'(0));
                ifc.in_valid = 1'b0;
                return;
            end
        end
        if (last_acc >= 0) begin
            chk("issue_interval_ge_10", 32'((cyc + 1 - last_acc) >= int'(W + 2)), 32'(1));
        end
        last_acc = cyc + 1;
        exp_q.push_back(exp);
        acc_cyc_q.push_back(cyc + 1);
        n_acc++;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        ifc.a        = ~a;
        ifc.b        = a ^ b;
        ifc.sgn      = ~s;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                chk("drain_timeout", 32'(exp_q.size()), 32'(0));
                exp_q.delete();
                acc_cyc_q.delete();
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_out_valid();
        int n;
        n = 0;
        while (!ifc.out_valid) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                chk("out_valid_timeout", 32'(ifc.out_valid), 32'(1));
                break;
            end
        end
    endtask

    // Monitor: latency on rising out_valid, product on each transfer
    always @(negedge clk) begin
        if (nrst) begin
            if (ifc.out_valid && !ov_prev) begin
                if (acc_cyc_q.size() == 0) begin
                    chk("unexpected_output", 32'(1), 32'(0));
                end else begin
                    chk("latency", 32'(cyc - acc_cyc_q[0]), 32'(W));
                end
            end
            if (ifc.out_valid && ifc.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("output_without_input", 32'(1), 32'(0));
                end else begin
                    chk("product", 32'(ifc.p), 32'(exp_q.pop_front()));
                    void'(acc_cyc_q.pop_front());
                    n_out++;
                end
            end
        end
        ov_prev = nrst ? ifc.out_valid : 1'b0;
    end

    // Random consumer backpressure during the randomised phase
    always @(posedge clk) begin
        if (rand_phase) begin
            #1 ifc.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;

        nrst          = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.sgn       = 1'b0;
        ifc.out_ready = 1'b1;
        #12;
        chk("reset_in_ready", 32'(ifc.in_ready), 32'(1));
        chk("reset_out_valid", 32'(ifc.out_valid), 32'(0));
        chk("reset_p", 32'(ifc.p), 32'(0));
        @(negedge clk);
        nrst = 1'b1;

        // Max unsigned, with in_ready returning one edge after valid
        issue(8'd255, 8'd255, 1'b0, 16'hFE01);
        wait_out_valid();
        chk("in_ready_low_in_done", 32'(ifc.in_ready), 32'(0));
        @(negedge clk);
        chk("in_ready_after_xfer", 32'(ifc.in_ready), 32'(1));
        wait_drain();

        issue(8'h80, 8'h80, 1'b1, 16'h4000);
        issue(8'hFD, 8'h07, 1'b1, 16'hFFEB);
        issue(8'h7F, 8'hFF, 1'b1, 16'hFF81);
        issue(8'hFF, 8'hFF, 1'b1, 16'h0001);
        issue(8'h00, 8'hAB, 1'b0, 16'h0000);
        issue(8'h00, 8'h80, 1'b1, 16'h0000);
        issue(8'h5A, 8'h01, 1'b0, 16'h005A);
        issue(8'h80, 8'h80, 1'b0, 16'h4000);
        wait_drain();

        // Backpressure: p held, in_ready low, in_valid pulses ignored
        ifc.out_ready = 1'b0;
        issue(8'd9, 8'd11, 1'b0, 16'd99);
        wait_out_valid();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            ifc.in_valid = (i % 2 == 0);
            ifc.a        = 8'(i * 7 + 3);
            ifc.b        = 8'(i * 5 + 1);
            @(negedge clk);
            chk("bp_p_stable", 32'(ifc.p), 32'(16'd99));
            chk("bp_in_ready_low", 32'(ifc.in_ready), 32'(0));
            chk("bp_out_valid_high", 32'(ifc.out_valid), 32'(1));
        end
        @(posedge clk); #1;
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        wait_drain();
        issue(8'd13, 8'd17, 1'b0, 16'd221);
        wait_drain();

        // Reset after the fourth RUN step drops the transaction
        issue(8'd200, 8'd100, 1'b0, 16'd20000);
        repeat (4) @(posedge clk);
        #1 nrst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(ifc.out_valid), 32'(0));
        chk("rst_p", 32'(ifc.p), 32'(0));
        chk("rst_in_ready", 32'(ifc.in_ready), 32'(1));
        exp_q.delete();
        acc_cyc_q.delete();
        n_acc--;
        last_acc = -1;
        @(negedge clk);
        nrst = 1'b1;
        issue(8'd12, 8'd12, 1'b0, 16'd144);
        wait_drain();

        // Randomised back-to-back against the reference product
        rand_phase = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(ra, rb, rs, ref_prod(ra, rb, rs));
        end
        rand_phase = 1'b0;
        @(posedge clk); #2;
        ifc.out_ready = 1'b1;
        wait_drain();
        chk("one_output_per_input", 32'(n_out), 32'(n_acc));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
